// File: rtl/bridge_mailbox.sv
// rtl/bridge_mailbox.sv - bridge-addressed H2C/C2H word mailbox with status, sticky errors and flush
// Window: 0 DATA, 1 STATUS (bits 31/30 W1C), 2 CONTROL (flush), 3 reserved.
module bridge_mailbox #(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] bridge_addr_i,
    input  logic        bridge_wr_i,
    input  logic [31:0] bridge_wr_data_i,
    input  logic        bridge_rd_i,
    output logic [31:0] bridge_rd_data_o,
    output logic [31:0] h2c_data_o,
    output logic        h2c_valid_o,
    input  logic        h2c_ready_i,
    input  logic [31:0] c2h_data_i,
    input  logic        c2h_valid_i,
    output logic        c2h_ready_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0] sel;
    logic       wr_data, wr_stat, wr_ctrl, rd_data_sel;
    logic       unused_addr;

    assign sel         = bridge_addr_i[3:2];
    assign wr_data     = bridge_wr_i && (sel == 2'd0);
    assign wr_stat     = bridge_wr_i && (sel == 2'd1);
    assign wr_ctrl     = bridge_wr_i && (sel == 2'd2);
    assign rd_data_sel = bridge_rd_i && !bridge_wr_i && (sel == 2'd0);
    assign unused_addr = ^{bridge_addr_i[31:4], bridge_addr_i[1:0]};

    logic [31:0]   h2c_mem [DEPTH];
    logic [AW-1:0] h2c_wr_q, h2c_wr_d, h2c_rd_q, h2c_rd_d;
    logic [CW-1:0] h2c_cnt_q, h2c_cnt_d;
    logic          h2c_full, h2c_push, h2c_pop, h2c_flush;

    logic [31:0]   c2h_mem [DEPTH];
    logic [AW-1:0] c2h_wr_q, c2h_wr_d, c2h_rd_q, c2h_rd_d;
    logic [CW-1:0] c2h_cnt_q, c2h_cnt_d;
    logic          c2h_full, c2h_empty, c2h_push, c2h_pop, c2h_flush;

    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [31:0]   status;

    // Fullness is judged on the pre-cycle count, so a same-cycle pop never makes room.
    assign h2c_full    = (h2c_cnt_q == FULL);
    assign h2c_valid_o = (h2c_cnt_q != '0);
    assign h2c_data_o  = h2c_valid_o ? h2c_mem[h2c_rd_q] : 32'd0;
    assign h2c_push    = wr_data && !h2c_full;
    assign h2c_pop     = h2c_valid_o && h2c_ready_i;
    assign h2c_flush   = wr_ctrl && bridge_wr_data_i[0];

    assign c2h_full    = (c2h_cnt_q == FULL);
    assign c2h_empty   = (c2h_cnt_q == '0);
    assign c2h_ready_o = !reset_i && !c2h_full;
    assign c2h_push    = c2h_valid_i && c2h_ready_o;
    assign c2h_pop     = rd_data_sel && !c2h_empty;
    assign c2h_flush   = wr_ctrl && bridge_wr_data_i[1];

    assign status = {ovf_q, unf_q, 5'd0, 9'(c2h_cnt_q), 7'd0, 9'(h2c_cnt_q)};

    always_comb begin
        h2c_wr_d  = h2c_wr_q;
        h2c_rd_d  = h2c_rd_q;
        h2c_cnt_d = h2c_cnt_q;
        if (h2c_flush) begin
            h2c_wr_d  = '0;
            h2c_rd_d  = '0;
            h2c_cnt_d = '0;
        end else begin
            if (h2c_push) h2c_wr_d = h2c_wr_q + AW'(1);
            if (h2c_pop)  h2c_rd_d = h2c_rd_q + AW'(1);
            h2c_cnt_d = h2c_cnt_q + CW'(h2c_push) - CW'(h2c_pop);
        end
    end

    always_comb begin
        c2h_wr_d  = c2h_wr_q;
        c2h_rd_d  = c2h_rd_q;
        c2h_cnt_d = c2h_cnt_q;
        if (c2h_flush) begin
            c2h_wr_d  = '0;
            c2h_rd_d  = '0;
            c2h_cnt_d = '0;
        end else begin
            if (c2h_push) c2h_wr_d = c2h_wr_q + AW'(1);
            if (c2h_pop)  c2h_rd_d = c2h_rd_q + AW'(1);
            c2h_cnt_d = c2h_cnt_q + CW'(c2h_push) - CW'(c2h_pop);
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (bridge_rd_i) begin
            if (bridge_wr_i) begin
                rd_data_d = 32'd0;
            end else begin
                case (sel)
                    2'd0:    rd_data_d = c2h_empty ? 32'hFFFF_FFFF : c2h_mem[c2h_rd_q];
                    2'd1:    rd_data_d = status;
                    default: rd_data_d = 32'd0;
                endcase
            end
        end
        ovf_d = (ovf_q && !(wr_stat && bridge_wr_data_i[31])) || (wr_data && h2c_full);
        unf_d = (unf_q && !(wr_stat && bridge_wr_data_i[30])) || (rd_data_sel && c2h_empty);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h2c_wr_q  <= '0;
            h2c_rd_q  <= '0;
            h2c_cnt_q <= '0;
            c2h_wr_q  <= '0;
            c2h_rd_q  <= '0;
            c2h_cnt_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            h2c_wr_q  <= h2c_wr_d;
            h2c_rd_q  <= h2c_rd_d;
            h2c_cnt_q <= h2c_cnt_d;
            c2h_wr_q  <= c2h_wr_d;
            c2h_rd_q  <= c2h_rd_d;
            c2h_cnt_q <= c2h_cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is not reset; counts gate every observable use of it.
    always_ff @(posedge clk_i) begin
        if (h2c_push) h2c_mem[h2c_wr_q] <= bridge_wr_data_i;
        if (c2h_push) c2h_mem[c2h_wr_q] <= c2h_data_i;
    end

    assign bridge_rd_data_o = rd_data_q;
endmodule

// File: tb/tb_bridge_mailbox.sv
// tb/tb_bridge_mailbox.sv - directed and randomized checks of bridge_mailbox against a queue model
module tb_bridge_mailbox;
    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] bridge_addr_i;
    logic        bridge_wr_i;
    logic [31:0] bridge_wr_data_i;
    logic        bridge_rd_i;
    logic [31:0] bridge_rd_data_o;
    logic [31:0] h2c_data_o;
    logic        h2c_valid_o;
    logic        h2c_ready_i;
    logic [31:0] c2h_data_i;
    logic        c2h_valid_i;
    logic        c2h_ready_o;

    bridge_mailbox #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .bridge_addr_i    (bridge_addr_i),
        .bridge_wr_i      (bridge_wr_i),
        .bridge_wr_data_i (bridge_wr_data_i),
        .bridge_rd_i      (bridge_rd_i),
        .bridge_rd_data_o (bridge_rd_data_o),
        .h2c_data_o       (h2c_data_o),
        .h2c_valid_o      (h2c_valid_o),
        .h2c_ready_i      (h2c_ready_i),
        .c2h_data_i       (c2h_data_i),
        .c2h_valid_i      (c2h_valid_i),
        .c2h_ready_o      (c2h_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    logic [31:0] mh2c[$];
    logic [31:0] mc2h[$];
    bit          m_ovf, m_unf;
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("h2c_valid", {31'd0, h2c_valid_o}, {31'd0, mh2c.size() > 0});
        chk("h2c_data", h2c_data_o, (mh2c.size() > 0) ? mh2c[0] : 32'd0);
        chk("c2h_ready", {31'd0, c2h_ready_o}, {31'd0, mc2h.size() < DEPTH});
        chk("rd_data", bridge_rd_data_o, m_rd);
    endtask

    // One clock cycle of stimulus; the model applies the mailbox rules to whole queues.
    task automatic step(input bit wr, input bit rd, input bit [1:0] sel, input logic [31:0] wd,
                        input bit hr, input bit cv, input logic [31:0] cd);
        int h_n, c_n;
        bit h_pop, c_push;
        logic [31:0] stat;
        bridge_wr_i      = wr;
        bridge_rd_i      = rd;
        bridge_addr_i    = ($urandom() & 32'hFFFF_FFF3) | {28'd0, sel, 2'b00};
        bridge_wr_data_i = wd;
        h2c_ready_i      = hr;
        c2h_valid_i      = cv;
        c2h_data_i       = cd;
        h_n    = mh2c.size();
        c_n    = mc2h.size();
        stat   = {m_ovf, m_unf, 5'd0, 9'(c_n), 7'd0, 9'(h_n)};
        h_pop  = hr && (h_n > 0);
        c_push = cv && (c_n < DEPTH);
        if (rd) begin
            if (wr) m_rd = 32'd0;
            else if (sel == 2'd0) m_rd = (c_n == 0) ? 32'hFFFF_FFFF : mc2h[0];
            else if (sel == 2'd1) m_rd = stat;
            else m_rd = 32'd0;
        end
        @(posedge clk_i);
        #1;
        if (h_pop) void'(mh2c.pop_front());
        if (wr && sel == 2'd0) begin
            if (h_n == DEPTH) m_ovf = 1'b1;
            else mh2c.push_back(wd);
        end
        if (wr && sel == 2'd1) begin
            if (wd[31]) m_ovf = 1'b0;
            if (wd[30]) m_unf = 1'b0;
        end
        if (rd && !wr && sel == 2'd0) begin
            if (c_n == 0) m_unf = 1'b1;
            else void'(mc2h.pop_front());
        end
        if (c_push) mc2h.push_back(cd);
        if (wr && sel == 2'd2) begin
            if (wd[0]) mh2c.delete();
            if (wd[1]) mc2h.delete();
        end
        bridge_wr_i = 1'b0;
        bridge_rd_i = 1'b0;
        h2c_ready_i = 1'b0;
        c2h_valid_i = 1'b0;
        check_outputs();
    endtask

    task automatic bwrite(input bit [1:0] sel, input logic [31:0] wd);
        step(1'b1, 1'b0, sel, wd, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic bread(input bit [1:0] sel);
        step(1'b0, 1'b1, sel, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset_i = 1'b1; bridge_addr_i = 0; bridge_wr_i = 0; bridge_wr_data_i = 0;
        bridge_rd_i = 0; h2c_ready_i = 0; c2h_data_i = 0; c2h_valid_i = 0;
        m_ovf = 0; m_unf = 0; m_rd = 0;
        #1;
        chk("reset_c2h_ready", {31'd0, c2h_ready_o}, 32'd0);
        chk("reset_h2c_valid", {31'd0, h2c_valid_o}, 32'd0);
        chk("reset_rd_data", bridge_rd_data_o, 32'd0);
        @(posedge clk_i); @(posedge clk_i);
        #3 reset_i = 1'b0;
        #1 chk("post_reset_c2h_ready", {31'd0, c2h_ready_o}, 32'd1);
        bread(2'd1);
        chk("idle_status", bridge_rd_data_o, 32'd0);

        for (int i = 0; i < 17; i++) bwrite(2'd0, 32'h100 + i);
        bread(2'd1);
        chk("h2c_full_status", bridge_rd_data_o, 32'h8000_0010);
        for (int i = 0; i < 16; i++) begin
            chk("h2c_stream_head", h2c_data_o, 32'h100 + i);
            step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        end
        chk("h2c_drained", {31'd0, h2c_valid_o}, 32'd0);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 32'hA0 + i);
        chk("c2h_full_ready", {31'd0, c2h_ready_o}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            bread(2'd0);
            chk("c2h_drain_word", bridge_rd_data_o, (i < 16) ? 32'hA0 + i : 32'hFFFF_FFFF);
        end
        bread(2'd1);
        chk("flags_both_set", bridge_rd_data_o, 32'hC000_0000);
        bwrite(2'd1, 32'hC000_0000);
        bread(2'd1);
        chk("flags_cleared", bridge_rd_data_o, 32'd0);

        for (int i = 0; i < 16; i++) bwrite(2'd0, 32'h200 + i);
        step(1'b1, 1'b0, 2'd0, 32'h2FF, 1'b1, 1'b0, 32'd0);
        bread(2'd1);
        chk("h2c_full_push_pop", bridge_rd_data_o, 32'h8000_000F);
        bwrite(2'd2, 32'h1);
        bwrite(2'd1, 32'h8000_0000);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 32'hB0 + i);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 32'hC0 + i);
        bread(2'd1);
        chk("c2h_push_pop_count", bridge_rd_data_o, 32'h0008_0000);
        for (int i = 0; i < 8; i++) begin
            bread(2'd0);
            chk("c2h_wrap_order", bridge_rd_data_o, 32'hC4 + i);
        end

        bread(2'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 32'hD0 + i);
        for (int i = 0; i < 3; i++) bwrite(2'd0, 32'h300 + i);
        step(1'b1, 1'b0, 2'd2, 32'h3, 1'b1, 1'b1, 32'hDEAD_BEEF);
        bread(2'd1);
        chk("flush_status", bridge_rd_data_o, 32'h4000_0000);
        bread(2'd0);
        chk("flush_no_word", bridge_rd_data_o, 32'hFFFF_FFFF);
        bwrite(2'd1, 32'hC000_0000);

        for (int n = 0; n < 400; n++) begin
            int r;
            bit wr, rd;
            bit [1:0] sel;
            logic [31:0] wd;
            r   = $urandom_range(0, 99);
            wr  = (r < 35) || (r >= 97);
            rd  = (r >= 35 && r < 70) || (r >= 97);
            sel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            wd  = $urandom();
            if (sel == 2'd2 && $urandom_range(0, 7) != 0) wd[1:0] = 2'b00;
            step(wr, rd, sel, wd, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), $urandom());
        end

        bwrite(2'd2, 32'h3);
        for (int i = 0; i < 5; i++) bwrite(2'd0, 32'h400 + i);
        bread(2'd1);
        #2 reset_i = 1'b1;
        #1;
        mh2c.delete(); mc2h.delete(); m_ovf = 0; m_unf = 0; m_rd = 0;
        chk("async_h2c_valid", {31'd0, h2c_valid_o}, 32'd0);
        chk("async_h2c_data", h2c_data_o, 32'd0);
        chk("async_rd_data", bridge_rd_data_o, 32'd0);
        @(posedge clk_i);
        #2 reset_i = 1'b0;
        #1 check_outputs();
        bread(2'd1);
        chk("after_async_status", bridge_rd_data_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bridge_mailbox.md
# bridge_mailbox

Bridge leaf that sits directly downstream of one `bridge_master` output port. It turns a 16-byte bridge window into a bidirectional mailbox:
- a host-to-core (H2C) FIFO, filled by bridge writes and drained by core logic through valid/ready;
- a core-to-host (C2H) FIFO, filled by core logic through valid/ready and drained by bridge reads.

Status, sticky error flags and flush controls are bridge-accessible, so APF-side software can stream words to and from the core without per-word handshaking registers.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, 2..256.
- `clk`  in  1  bridge clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears pointers, counts and flags.
- `bridge_addr`  in  32  byte address; only `[3:2]` decoded (upstream already gates selection).
- `bridge_wr`  in  1  one-cycle write strobe.
- `bridge_wr_data`  in  32  write data, valid with `bridge_wr`.
- `bridge_rd`  in  1  one-cycle read strobe.
- `bridge_rd_data`  out  32  registered read data.
- `h2c_data`  out  32  H2C FIFO head word; forced 0 when `h2c_valid`=0.
- `h2c_valid`  out  1  H2C FIFO non-empty.
- `h2c_ready`  in  1  core pops H2C head when `h2c_valid && h2c_ready`.
- `c2h_data`  in  32  word pushed by core.
- `c2h_valid`  in  1  core push request.
- `c2h_ready`  out  1  C2H FIFO not full; 0 while `reset` high.

## Operation
- **Register map**, selected by `addr[3:2]`:
  - **0 DATA**
    - Write pushes `bridge_wr_data` into H2C. If H2C is full, the word is dropped and sticky `h2c_overflow` is set.
    - Read pops C2H; `bridge_rd_data` is the popped word. If C2H is empty, it returns 32'hFFFF_FFFF, no pop occurs, and sticky `c2h_underflow` is set.
  - **1 STATUS**
    - Read returns: `[8:0]`=H2C count, `[24:16]`=C2H count, `[30]`=`c2h_underflow`, `[31]`=`h2c_overflow`, all other bits 0.
    - Write: bits 31/30 are write-1-to-clear; other bits are ignored.
  - **2 CONTROL**
    - Write bit0=1 flushes H2C; write bit1=1 flushes C2H. Flush resets pointers and count to 0.
    - Read returns 0.
  - **3**: read returns 0; writes ignored.
- **FIFO storage**
  - Each FIFO is a DEPTH×32 circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap at DEPTH.
  - Counts are `$clog2(DEPTH)+1` bits, range 0..DEPTH, zero-extended into the STATUS fields.
  - Full means count==DEPTH; empty means count==0.
- **Show-ahead H2C**: `h2c_data` is `mem[rd_ptr]` whenever `h2c_valid`=1.
- **Simultaneous push and pop on the same FIFO**
  - Both occur; count is unchanged.
  - When full, a pop in the same cycle does NOT make room for a push. The push is judged against pre-cycle count: a bridge write is dropped with overflow, and `c2h_ready` is already 0.
  - When empty, the pop is invalid and only the push happens.
- **Flush collisions**
  - A flush in the same cycle as a push or pop on that FIFO: flush wins. The concurrent push is discarded even if handshaked. A concurrent core pop of H2C is considered consumed.
  - A flush leaves the sticky flags unchanged.
- **Sticky set vs W1C in the same cycle**: set wins.
- `bridge_wr` and `bridge_rd` are never asserted together (upstream guarantee). If they are, the write is performed and the read returns 0.

## Timing
- **Reset values**:
  - `bridge_rd_data`=0
  - `h2c_valid`=0, `h2c_data`=0
  - `c2h_ready`=0 during reset, 1 on the first cycle after deassertion
  - counts, pointers and flags = 0
- **Read latency**: `bridge_rd` at cycle N → `bridge_rd_data` valid from N+1 and held until the next `bridge_rd`. A C2H pop takes effect at the N edge.
- **Bridge write to DATA** at N → `h2c_valid`=1 and STATUS count updated from N+1.
- **Core handshake**
  - Pop at N → next head word (or `h2c_valid`=0) at N+1.
  - Push at N → C2H count +1 at N+1; word readable by a `bridge_rd` issued at N+1.
- **Back-to-back**: bridge accesses every cycle and continuous core handshakes are sustained with no bubbles.
- **Reset mid-operation**: contents are abandoned immediately (asynchronous); there is no partial-transfer recovery.

## Test plan
- **Reset then idle**: after reset, STATUS read returns 0, `h2c_valid`=0, and `c2h_ready`=1 one cycle after deassertion.
- **H2C stream with overflow** (DEPTH=16)
  - 17 DATA writes of 0x100+i with `h2c_ready`=0: STATUS reads count 16 with bit31=1.
  - Raise `h2c_ready`: the core sees 0x100..0x10F in order, and `h2c_valid` drops after 16 pops.
- **C2H fill and drain**
  - Core pushes 0xA0..0xAF: `c2h_ready`=0 after the 16th.
  - 17 DATA reads return 0xA0..0xAF then 0xFFFF_FFFF; STATUS bit30=1.
  - A W1C write of 0xC000_0000 clears both flags.
- **Simultaneous push/pop at full**
  - H2C full: a bridge write plus a core pop in one cycle leaves the count at 15 with overflow set.
  - C2H at count 8: a core push plus a bridge pop keeps the count at 8, and the data order is preserved across pointer wrap.
- **Flush collision**: CONTROL write 0x3 in the same cycle as a handshaked core push: both counts read 0, the pushed word never appears, and the sticky flags are unchanged.
- **Async reset mid-stream**: assert `reset` while H2C holds 5 words: `h2c_valid`, `h2c_data` and `bridge_rd_data` go 0 without waiting for a clock edge.
